test_pattern_gen: RTL and testbench
===================================

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter X_SIZE, default 640, active pixels per line (>=2).
REQ-002 SHALL have parameter Y_SIZE, default 480, lines per frame (>=2).
REQ-003 SHALL have parameter COLOR_W, default 8, bits per colour component.
REQ-004 SHALL have parameter CHECK_LOG2, default 4, log2 of checkerboard cell size in pixels.
REQ-005 SHALL have port aclk  in  1  single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port cfg_enable  in  1  run request.
REQ-008 SHALL have port cfg_mode  in  2  pattern select: 0 gradient, 1 solid, 2 colour bars, 3 checkerboard.
REQ-009 SHALL have port cfg_frame_adv  in  COLOR_W  per-frame offset increment.
REQ-010 SHALL have port cfg_color  in  3*COLOR_W  solid colour {r,g,b}.
REQ-011 SHALL have port out_stream_tdata  out  3*COLOR_W  pixel {r,g,b}, r in MSBs.
REQ-012 SHALL have port out_stream_tvalid  out  1  pixel valid.
REQ-013 SHALL have port out_stream_tready  in  1  downstream ready.
REQ-014 SHALL have port out_stream_tlast  out  1  last pixel of line (x == X_SIZE-1).
REQ-015 SHALL have port out_stream_tuser  out  1  start of frame (x == 0, y == 0).
REQ-016 SHALL have port frame_count  out  COLOR_W  current frame offset.
REQ-017 SHALL have port busy  out  1  high while state is ACTIVE.

Function
REQ-018 SHALL implement states IDLE and ACTIVE; IDLE->ACTIVE when cfg_enable=1 in IDLE; ACTIVE->IDLE when the last pixel of a frame (x=X_SIZE-1, y=Y_SIZE-1) is accepted with cfg_enable=0.
REQ-019 SHALL treat a beat as accepted when tvalid & tready are both 1 on a rising edge.
REQ-020 SHALL register all stream outputs; tdata, tlast and tuser SHALL hold stable while tvalid=1 and tready=0.
REQ-021 SHALL load a new beat when ACTIVE and (tvalid=0 or the current beat is accepted); first tvalid SHALL assert one cycle after the IDLE->ACTIVE transition edge, carrying pixel (0,0) with tuser=1.
REQ-022 SHALL, with tready held 1, sustain one pixel per cycle with no bubbles, including across line and frame wrap.
REQ-023 SHALL advance x on each loaded beat, wrap x to 0 after X_SIZE-1 and then advance y; wrap y to 0 after Y_SIZE-1.
REQ-024 SHALL, when a frame's last pixel is accepted, add cfg_frame_adv to frame_count modulo 2^COLOR_W.
REQ-025 SHALL sample cfg_mode and cfg_color only when loading pixel (0,0); changes mid-frame SHALL NOT affect the current frame.
REQ-026 Mode 0 SHALL output r = x[COLOR_W-1:0]+F, g = x[COLOR_W-2:0]+y[COLOR_W-2:0]+F, b = y[COLOR_W-1:0]+F, all modulo 2^COLOR_W, F = frame_count.
REQ-027 Mode 1 SHALL output the latched cfg_color.
REQ-028 Mode 2 SHALL output 8 bars, bar index i = (x*8)/X_SIZE, r = all-ones if i[2], g if i[1], b if i[0], else zero (i=0 white... i=7 per bit mapping, inverted: component = all-ones when bit of (7-i) set).
REQ-029 Mode 3 SHALL output all-ones on all components when x[CHECK_LOG2] XOR y[CHECK_LOG2] = 0, else zero, each component XORed with F.
REQ-030 SHALL drop tvalid to 0 on the cycle after the final beat is accepted on ACTIVE->IDLE; x, y reset to 0; frame_count retained.
REQ-031 SHALL, when cfg_enable deasserts mid-frame, complete the frame; re-asserting before the final pixel SHALL continue seamlessly into the next frame.

Reset
REQ-032 SHALL, while aresetn=0, immediately force state IDLE, tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, x=0, y=0, frame_count=0, regardless of clock.
REQ-033 SHALL, on reset assertion mid-frame, discard the in-flight beat; after release the next frame SHALL start at (0,0) with tuser=1.

Verification (X_SIZE=4, Y_SIZE=2, COLOR_W=8, CHECK_LOG2=1)
REQ-034 Reset then cfg_enable=1, mode 0, adv=1, tready=1 -> beats (0,0)..(3,1) tdata r/g/b = x/x+y/y, tlast on beats 4 and 8, tuser on beat 1; second frame beat 1 r=1, frame_count=1.
REQ-035 Mode 0, tready toggled 1,0,0,1 every beat -> tdata/tlast/tuser unchanged during tready=0; no pixel skipped or repeated.
REQ-036 cfg_enable dropped after beat 3 -> 8 beats total, tvalid=0 and busy=0 the cycle after beat 8; frame_count=adv.
REQ-037 Mode 1 cfg_color=0x123456, switch to mode 0 at beat 2 -> all 8 beats 0x123456; next frame gradient.
REQ-038 Mode 3, F=0 -> row 0 tdata FFFFFF,FFFFFF,000000,000000; row 1 identical (y[1]=0).
REQ-039 aresetn pulsed low at beat 5 without a clock edge -> tvalid=0 immediately; after release and enable, first beat is (0,0), tuser=1, frame_count=0.

Source files
------------

// File: rtl/test_pattern_gen.sv
// Test pattern generator: emits an AXI4-Stream video raster of X_SIZE x Y_SIZE
// pixels in one of four patterns (gradient, solid, colour bars, checkerboard).
// A per-frame offset accumulates by cfg_frame_adv to animate the patterns.

module test_pattern_gen #(
  parameter int X_SIZE     = 640,
  parameter int Y_SIZE     = 480,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_mode,
  input  logic [COLOR_W-1:0]   cfg_frame_adv,
  input  logic [3*COLOR_W-1:0] cfg_color,
  output logic [3*COLOR_W-1:0] out_stream_tdata,
  output logic                 out_stream_tvalid,
  input  logic                 out_stream_tready,
  output logic                 out_stream_tlast,
  output logic                 out_stream_tuser,
  output logic [COLOR_W-1:0]   frame_count,
  output logic                 busy
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [COLOR_W-1:0]    r_frameCount;
  logic                  r_tvalid;
  logic [3*COLOR_W-1:0]  r_tdata;
  logic                  r_tlast;
  logic                  r_tuser;
  logic                  r_lastOfFrame;
  logic [1:0]            r_mode;
  logic [3*COLOR_W-1:0]  r_color;

  logic                  w_accept;
  logic                  w_frameDone;
  logic                  w_load;
  logic                  w_xLast;
  logic                  w_yLast;
  logic                  w_atOrigin;
  logic [COLOR_W-1:0]    w_nextFrameCount;
  logic [COLOR_W-1:0]    w_F;
  logic [1:0]            w_pixMode;
  logic [3*COLOR_W-1:0]  w_pixColor;
  logic [COLOR_W-1:0]    w_xLow;
  logic [COLOR_W-1:0]    w_yLow;
  logic [2:0]            w_barIdx;
  logic [2:0]            w_barInv;
  logic                  w_xChk;
  logic                  w_yChk;
  logic [COLOR_W-1:0]    w_chkComp;
  logic [3*COLOR_W-1:0]  w_pixel;

  // Handshake and raster position decode; r_x/r_y always name the next pixel to load.
  assign w_accept         = r_tvalid & out_stream_tready;
  assign w_frameDone      = w_accept & r_lastOfFrame;
  assign w_xLast          = (r_x == XW'(X_SIZE - 1));
  assign w_yLast          = (r_y == YW'(Y_SIZE - 1));
  assign w_atOrigin       = (r_x == '0) && (r_y == '0);
  assign w_nextFrameCount = r_frameCount + cfg_frame_adv;

  // Pixel (0,0) of a frame loaded on the same edge the previous frame ends must already
  // see the advanced offset, so forward the sum in that case.
  assign w_F = w_frameDone ? w_nextFrameCount : r_frameCount;

  // Mode and colour come straight from the config inputs at the frame origin and from
  // the latched copies for the rest of the frame.
  assign w_pixMode  = w_atOrigin ? cfg_mode  : r_mode;
  assign w_pixColor = w_atOrigin ? cfg_color : r_color;

  assign w_xLow    = COLOR_W'(r_x);
  assign w_yLow    = COLOR_W'(r_y);
  assign w_barIdx  = 3'((32'(r_x) * 32'd8) / 32'(X_SIZE));
  assign w_barInv  = ~w_barIdx;
  assign w_xChk    = 1'(32'(r_x) >> CHECK_LOG2);
  assign w_yChk    = 1'(32'(r_y) >> CHECK_LOG2);
  assign w_chkComp = {COLOR_W{~(w_xChk ^ w_yChk)}} ^ w_F;

  // Pattern generation for the pixel at (r_x, r_y).
  always_comb begin
    w_pixel = '0;
    case (w_pixMode)
      2'd0: w_pixel = {w_xLow + w_F,
                       COLOR_W'(w_xLow[COLOR_W-2:0]) + COLOR_W'(w_yLow[COLOR_W-2:0]) + w_F,
                       w_yLow + w_F};
      2'd1: w_pixel = w_pixColor;
      2'd2: w_pixel = {{COLOR_W{w_barInv[2]}}, {COLOR_W{w_barInv[1]}}, {COLOR_W{w_barInv[0]}}};
      2'd3: w_pixel = {w_chkComp, w_chkComp, w_chkComp};
      default: w_pixel = '0;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and load strobe: stop only once the final pixel of a frame leaves with
  // enable low, otherwise keep the output register full whenever it empties or drains.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_enable) begin
          w_nextState = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_frameDone && !cfg_enable) begin
          w_nextState = ST_IDLE;
        end else if (!r_tvalid || w_accept) begin
          w_load = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output register, raster counters, frame offset and per-frame config latch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frameCount  <= '0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_lastOfFrame <= 1'b0;
      r_mode        <= '0;
      r_color       <= '0;
    end else begin
      if (w_frameDone) begin
        r_frameCount <= w_nextFrameCount;
      end
      if (w_load) begin
        r_tvalid      <= 1'b1;
        r_tdata       <= w_pixel;
        r_tlast       <= w_xLast;
        r_tuser       <= w_atOrigin;
        r_lastOfFrame <= w_xLast & w_yLast;
        if (w_atOrigin) begin
          r_mode  <= cfg_mode;
          r_color <= cfg_color;
        end
        if (w_xLast) begin
          r_x <= '0;
          r_y <= w_yLast ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign out_stream_tdata  = r_tdata;
  assign out_stream_tvalid = r_tvalid;
  assign out_stream_tlast  = r_tlast;
  assign out_stream_tuser  = r_tuser;
  assign frame_count       = r_frameCount;
  assign busy              = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed table-driven bench for test_pattern_gen on a 4x2 raster.

module tb_test_pattern_gen;

  localparam int X_SIZE     = 4;
  localparam int Y_SIZE     = 2;
  localparam int COLOR_W    = 8;
  localparam int CHECK_LOG2 = 1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_frame_adv;
  logic [23:0] cfg_color;
  logic [23:0] out_stream_tdata;
  logic        out_stream_tvalid;
  logic        out_stream_tready;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic [7:0]  frame_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  adv;
    logic [23:0] color;
    logic        rdy;
    logic        expValid;
    logic [23:0] expData;
    logic        expLast;
    logic        expUser;
    logic        expBusy;
    logic [7:0]  expFc;
  } vec_t;

  vec_t vecs[$];

  test_pattern_gen #(
    .X_SIZE    (X_SIZE),
    .Y_SIZE    (Y_SIZE),
    .COLOR_W   (COLOR_W),
    .CHECK_LOG2(CHECK_LOG2)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_enable       (cfg_enable),
    .cfg_mode         (cfg_mode),
    .cfg_frame_adv    (cfg_frame_adv),
    .cfg_color        (cfg_color),
    .out_stream_tdata (out_stream_tdata),
    .out_stream_tvalid(out_stream_tvalid),
    .out_stream_tready(out_stream_tready),
    .out_stream_tlast (out_stream_tlast),
    .out_stream_tuser (out_stream_tuser),
    .frame_count      (frame_count),
    .busy             (busy)
  );

  always #5 aclk = ~aclk;

  task automatic addVec(input logic en, input logic [1:0] mode, input logic [7:0] adv,
                        input logic [23:0] color, input logic rdy, input logic expValid,
                        input logic [23:0] expData, input logic expLast, input logic expUser,
                        input logic expBusy, input logic [7:0] expFc);
    vec_t v;
    v.en = en; v.mode = mode; v.adv = adv; v.color = color; v.rdy = rdy;
    v.expValid = expValid; v.expData = expData; v.expLast = expLast;
    v.expUser = expUser; v.expBusy = expBusy; v.expFc = expFc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    cfg_enable        = v.en;
    cfg_mode          = v.mode;
    cfg_frame_adv     = v.adv;
    cfg_color         = v.color;
    out_stream_tready = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    logic ok;
    total++;
    if (v.expValid) begin
      ok = (out_stream_tvalid === 1'b1) && (out_stream_tdata === v.expData) &&
           (out_stream_tlast === v.expLast) && (out_stream_tuser === v.expUser) &&
           (busy === v.expBusy) && (frame_count === v.expFc);
    end else begin
      ok = (out_stream_tvalid === 1'b0) && (busy === v.expBusy) && (frame_count === v.expFc);
    end
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s[%0d]: got valid=%0b data=%06h last=%0b user=%0b busy=%0b fc=%02h, want valid=%0b data=%06h last=%0b user=%0b busy=%0b fc=%02h",
               tag, idx, out_stream_tvalid, out_stream_tdata, out_stream_tlast, out_stream_tuser,
               busy, frame_count, v.expValid, v.expData, v.expLast, v.expUser, v.expBusy, v.expFc);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Each row: inputs driven at a falling edge, outputs checked at the next falling edge.
  task automatic runVectors(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge aclk);
      checkOutput(vecs[i], tag, i);
    end
    vecs.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_tvalid"}, 32'(out_stream_tvalid), 32'd0);
    checkValue({tag, "_tdata"},  32'(out_stream_tdata),  32'd0);
    checkValue({tag, "_tlast"},  32'(out_stream_tlast),  32'd0);
    checkValue({tag, "_tuser"},  32'(out_stream_tuser),  32'd0);
    checkValue({tag, "_busy"},   32'(busy),              32'd0);
    checkValue({tag, "_fc"},     32'(frame_count),       32'd0);
  endtask

  initial begin
    aresetn           = 1'b0;
    cfg_enable        = 1'b0;
    cfg_mode          = 2'd0;
    cfg_frame_adv     = 8'd0;
    cfg_color         = 24'd0;
    out_stream_tready = 1'b0;

    #3;
    checkResetState("por");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // Gradient, adv=1, two frames; enable dropped mid second frame so it drains to idle.
    $display("[TB] gradient two frames");
    addVec(1, 0, 1, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h000000, 0, 1, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h010100, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h020200, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h030300, 1, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h000101, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h010201, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h020301, 0, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h030401, 1, 0, 1, 8'h00);
    addVec(1, 0, 1, 0, 1, 1, 24'h010101, 0, 1, 1, 8'h01);
    addVec(1, 0, 1, 0, 1, 1, 24'h020201, 0, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h030301, 0, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h040401, 1, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h010202, 0, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h020302, 0, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h030402, 0, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 1, 24'h040502, 1, 0, 1, 8'h01);
    addVec(0, 0, 1, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h02);
    addVec(0, 0, 1, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h02);
    runVectors("grad");

    // Backpressure with tready 1,0,0,1 per cycle; enable dropped after beat 3.
    $display("[TB] backpressure");
    addVec(1, 0, 1, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h02);
    addVec(1, 0, 1, 0, 1, 1, 24'h020202, 0, 1, 1, 8'h02);
    addVec(1, 0, 1, 0, 1, 1, 24'h030302, 0, 0, 1, 8'h02);
    addVec(1, 0, 1, 0, 0, 1, 24'h030302, 0, 0, 1, 8'h02);
    addVec(1, 0, 1, 0, 0, 1, 24'h030302, 0, 0, 1, 8'h02);
    addVec(1, 0, 1, 0, 1, 1, 24'h040402, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 1, 24'h050502, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h050502, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h050502, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 1, 24'h020303, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 1, 24'h030403, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h030403, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h030403, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 1, 24'h040503, 0, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 1, 24'h050603, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h050603, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 0, 1, 24'h050603, 1, 0, 1, 8'h02);
    addVec(0, 0, 1, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h03);
    runVectors("bp");

    // Solid colour latched at frame start; mode/colour changes mid-frame are ignored.
    $display("[TB] solid colour latch");
    addVec(1, 1, 5, 24'h123456, 1, 0, 24'h000000, 0, 0, 1, 8'h03);
    addVec(1, 1, 5, 24'h123456, 1, 1, 24'h123456, 0, 1, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 0, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 0, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 1, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 0, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 0, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 0, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h123456, 1, 0, 1, 8'h03);
    addVec(1, 0, 5, 24'hABCDEF, 1, 1, 24'h080808, 0, 1, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h090908, 0, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h0A0A08, 0, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h0B0B08, 1, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h080909, 0, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h090A09, 0, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h0A0B09, 0, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 1, 24'h0B0C09, 1, 0, 1, 8'h08);
    addVec(0, 0, 5, 24'hABCDEF, 1, 0, 24'h000000, 0, 0, 0, 8'h0D);
    runVectors("solid");

    // Colour bars: x=0..3 maps to bar 0,2,4,6.
    $display("[TB] colour bars");
    addVec(1, 2, 0, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h0D);
    addVec(1, 2, 0, 0, 1, 1, 24'hFFFFFF, 0, 1, 1, 8'h0D);
    addVec(1, 2, 0, 0, 1, 1, 24'hFF00FF, 0, 0, 1, 8'h0D);
    addVec(1, 2, 0, 0, 1, 1, 24'h00FFFF, 0, 0, 1, 8'h0D);
    addVec(1, 2, 0, 0, 1, 1, 24'h0000FF, 1, 0, 1, 8'h0D);
    addVec(0, 2, 0, 0, 1, 1, 24'hFFFFFF, 0, 0, 1, 8'h0D);
    addVec(0, 2, 0, 0, 1, 1, 24'hFF00FF, 0, 0, 1, 8'h0D);
    addVec(0, 2, 0, 0, 1, 1, 24'h00FFFF, 0, 0, 1, 8'h0D);
    addVec(0, 2, 0, 0, 1, 1, 24'h0000FF, 1, 0, 1, 8'h0D);
    addVec(0, 2, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h0D);
    runVectors("bars");

    // Asynchronous reset in the middle of a frame, between clock edges.
    $display("[TB] mid-frame reset");
    addVec(1, 0, 5, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h0D);
    addVec(1, 0, 5, 0, 1, 1, 24'h0D0D0D, 0, 1, 1, 8'h0D);
    addVec(1, 0, 5, 0, 1, 1, 24'h0E0E0D, 0, 0, 1, 8'h0D);
    addVec(1, 0, 5, 0, 1, 1, 24'h0F0F0D, 0, 0, 1, 8'h0D);
    addVec(1, 0, 5, 0, 1, 1, 24'h10100D, 1, 0, 1, 8'h0D);
    addVec(1, 0, 5, 0, 1, 1, 24'h0D0E0E, 0, 0, 1, 8'h0D);
    runVectors("prereset");
    #2;
    aresetn = 1'b0;
    #1;
    checkResetState("async");
    cfg_enable = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    addVec(1, 0, 0, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h00);
    addVec(1, 0, 0, 0, 1, 1, 24'h000000, 0, 1, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h010100, 0, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h020200, 0, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h030300, 1, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h000101, 0, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h010201, 0, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h020301, 0, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 1, 24'h030401, 1, 0, 1, 8'h00);
    addVec(0, 0, 0, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h00);
    runVectors("postreset");

    // Checkerboard with 2-pixel cells, first frame F=0 then F=0x0F.
    $display("[TB] checkerboard");
    addVec(1, 3, 8'h0F, 0, 1, 0, 24'h000000, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'hFFFFFF, 0, 1, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'hFFFFFF, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'h000000, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'h000000, 1, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'hFFFFFF, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'hFFFFFF, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'h000000, 0, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'h000000, 1, 0, 1, 8'h00);
    addVec(1, 3, 8'h0F, 0, 1, 1, 24'hF0F0F0, 0, 1, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'hF0F0F0, 0, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'h0F0F0F, 0, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'h0F0F0F, 1, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'hF0F0F0, 0, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'hF0F0F0, 0, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'h0F0F0F, 0, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 1, 24'h0F0F0F, 1, 0, 1, 8'h0F);
    addVec(0, 3, 8'h0F, 0, 1, 0, 24'h000000, 0, 0, 0, 8'h1E);
    runVectors("check");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
